// File: rtl/mux_scan_nto1.sv
// Registered N:1 channel mux with direct-select and timed scan modes.
// Optional macro CH_MASK_EN adds a ch_mask input restricting which channels are legal/visited.
module mux_scan_nto1 #(
    parameter  int N_CH  = 16,
    parameter  int WIDTH = 1,
    parameter  int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  en,
`ifdef CH_MASK_EN
    input  logic [N_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_ch,
    output logic                  wrap,
    output logic                  sel_err,
    output logic [1:0]            dbg_state
);

    localparam int DW_W = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  out_q;
    logic              valid_q;
    logic [SEL_W-1:0]  cur_ch_q;
    logic              wrap_q;
    logic              sel_err_q;
    logic [DW_W-1:0]   dwell_q;

    logic [N_CH-1:0]   mask_w;
    logic [SEL_W-1:0]  first_ch;
    logic              first_found;
    logic [SEL_W-1:0]  adv_ch_d;
    logic              adv_found;
    logic              adv_wrap_d;
    logic              any_en;
    logic              sel_legal;
    logic              sel_en;

`ifdef CH_MASK_EN
    assign mask_w = ch_mask;
`else
    assign mask_w = '1;
`endif

    function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] v,
                                              input logic [SEL_W-1:0]      idx);
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) pick = v[k*WIDTH +: WIDTH];
        end
    endfunction

    // Lowest enabled channel, and next enabled channel strictly above cur_ch.
    // When nothing lies above, the scan wraps to the lowest enabled channel.
    always_comb begin
        first_ch    = '0;
        first_found = 1'b0;
        adv_ch_d    = '0;
        adv_found   = 1'b0;
        sel_en      = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (mask_w[k] && !first_found) begin
                first_ch    = SEL_W'(k);
                first_found = 1'b1;
            end
            if (mask_w[k] && !adv_found && (k > int'(cur_ch_q))) begin
                adv_ch_d  = SEL_W'(k);
                adv_found = 1'b1;
            end
            if (int'(sel) == k) sel_en = mask_w[k];
        end
        if (!adv_found) adv_ch_d = first_ch;
        adv_wrap_d = !adv_found;
    end

    assign any_en    = |mask_w;
    assign sel_legal = int'(sel) < N_CH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_q     <= '0;
            valid_q   <= 1'b0;
            cur_ch_q  <= '0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
            dwell_q   <= '0;
        end else if (!en) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
            dwell_q   <= '0;
        end else if (!mode) begin
            state_q <= DIRECT;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            if (sel_en) begin
                out_q     <= pick(in, sel);
                cur_ch_q  <= sel;
                valid_q   <= 1'b1;
                sel_err_q <= 1'b0;
            end else begin
                // Masked-but-legal selects read as zero without flagging an error.
                out_q     <= '0;
                valid_q   <= 1'b0;
                sel_err_q <= !sel_legal;
            end
        end else begin
            state_q   <= SCAN;
            sel_err_q <= 1'b0;
            if (!any_en) begin
                valid_q <= 1'b0;
                wrap_q  <= 1'b0;
                dwell_q <= '0;
            end else if (state_q != SCAN) begin
                cur_ch_q <= first_ch;
                out_q    <= pick(in, first_ch);
                dwell_q  <= '0;
                valid_q  <= 1'b1;
                wrap_q   <= 1'b0;
            end else if (dwell_q == DW_W'(DWELL - 1)) begin
                cur_ch_q <= adv_ch_d;
                out_q    <= pick(in, adv_ch_d);
                dwell_q  <= '0;
                valid_q  <= 1'b1;
                wrap_q   <= adv_wrap_d;
            end else begin
                out_q   <= pick(in, cur_ch_q);
                dwell_q <= dwell_q + DW_W'(1);
                valid_q <= 1'b1;
                wrap_q  <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign cur_ch    = cur_ch_q;
    assign wrap      = wrap_q;
    assign sel_err   = sel_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: 16x1 DWELL=1 and 5x8 DWELL=3 instances,
// plus an 8x4 masked instance when CH_MASK_EN is defined.
module tb_mux_scan_nto1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 16 channels x 1 bit, DWELL=1
    logic [15:0] in16 = '0;
    logic [3:0]  sel16 = '0;
    logic        mode16 = 1'b0, en16 = 1'b0;
    logic        o16, v16, w16, e16;
    logic [3:0]  c16;
    logic [1:0]  s16;

    // 5 channels x 8 bits, DWELL=3
    logic [39:0] in5 = '0;
    logic [2:0]  sel5 = '0;
    logic        mode5 = 1'b0, en5 = 1'b0;
    logic [7:0]  o5;
    logic        v5, w5, e5;
    logic [2:0]  c5;
    logic [1:0]  s5;

`ifdef CH_MASK_EN
    logic [15:0] mask16 = '1;
    logic [4:0]  mask5 = '1;
    logic [31:0] in8 = '0;
    logic [2:0]  sel8 = '0;
    logic        mode8 = 1'b0, en8 = 1'b0;
    logic [7:0]  mask8 = '1;
    logic [3:0]  o8;
    logic        v8, w8, e8;
    logic [2:0]  c8;
    logic [1:0]  s8;
`endif

    mux_scan_nto1 #(.N_CH(16), .WIDTH(1), .DWELL(1)) u16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .sel(sel16), .mode(mode16), .en(en16),
`ifdef CH_MASK_EN
        .ch_mask(mask16),
`endif
        .out(o16), .out_valid(v16), .cur_ch(c16), .wrap(w16), .sel_err(e16), .dbg_state(s16)
    );

    mux_scan_nto1 #(.N_CH(5), .WIDTH(8), .DWELL(3)) u5 (
        .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel5), .mode(mode5), .en(en5),
`ifdef CH_MASK_EN
        .ch_mask(mask5),
`endif
        .out(o5), .out_valid(v5), .cur_ch(c5), .wrap(w5), .sel_err(e5), .dbg_state(s5)
    );

`ifdef CH_MASK_EN
    mux_scan_nto1 #(.N_CH(8), .WIDTH(4), .DWELL(1)) u8m (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .mode(mode8), .en(en8),
        .ch_mask(mask8),
        .out(o8), .out_valid(v8), .cur_ch(c8), .wrap(w8), .sel_err(e8), .dbg_state(s8)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en16 = 1'b0; en5 = 1'b0;
`ifdef CH_MASK_EN
        en8 = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in16 = '1; mode16 = 1'b1; en16 = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (o16 !== 1'b0) begin n_fail++; $display("FAIL reset_out cyc=%0d got=%0h exp=0", i, o16); end
            n_tests++; if (v16 !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc=%0d got=%0h exp=0", i, v16); end
            n_tests++; if (c16 !== 4'd0) begin n_fail++; $display("FAIL reset_cur cyc=%0d got=%0d exp=0", i, c16); end
            n_tests++; if (w16 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap cyc=%0d got=%0h exp=0", i, w16); end
        end
        n_tests++; if (o5 !== 8'd0 || v5 !== 1'b0 || e5 !== 1'b0) begin n_fail++; $display("FAIL reset_u5 got out=%0d valid=%0d err=%0d exp 0/0/0", o5, v5, e5); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (c16 !== 4'd0 || o16 !== 1'b1 || v16 !== 1'b1 || w16 !== 1'b0)
            begin n_fail++; $display("FAIL reset_first_scan got cur=%0d out=%0d valid=%0d wrap=%0d exp 0/1/1/0", c16, o16, v16, w16); end
    endtask

    task automatic test_direct_sweep();
        logic exp_bits [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        in16 = 16'h00A5; mode16 = 1'b0; en16 = 1'b1;
        for (int s = 0; s < 16; s++) begin
            sel16 = 4'(s);
            tick();
            n_tests++; if (o16 !== exp_bits[s]) begin n_fail++; $display("FAIL direct_out sel=%0d got=%0d exp=%0d", s, o16, exp_bits[s]); end
            n_tests++; if (v16 !== 1'b1 || e16 !== 1'b0) begin n_fail++; $display("FAIL direct_flags sel=%0d got valid=%0d err=%0d exp 1/0", s, v16, e16); end
            n_tests++; if (c16 !== 4'(s)) begin n_fail++; $display("FAIL direct_cur sel=%0d got=%0d exp=%0d", s, c16, s); end
        end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] ec;
        logic eo, ew;
        do_reset();
        in16 = 16'h8001; mode16 = 1'b1; en16 = 1'b1; sel16 = 4'd5;
        for (int c = 0; c < 48; c++) begin
            tick();
            ec = 4'(c % 16);
            eo = (ec == 4'd0) || (ec == 4'd15);
            ew = (ec == 4'd0) && (c > 0);
            n_tests++; if (c16 !== ec) begin n_fail++; $display("FAIL scan_cur cyc=%0d got=%0d exp=%0d", c, c16, ec); end
            n_tests++; if (o16 !== eo || v16 !== 1'b1) begin n_fail++; $display("FAIL scan_out cyc=%0d got out=%0d valid=%0d exp %0d/1", c, o16, v16, eo); end
            n_tests++; if (w16 !== ew || e16 !== 1'b0) begin n_fail++; $display("FAIL scan_wrap cyc=%0d got wrap=%0d err=%0d exp %0d/0", c, w16, e16, ew); end
        end
    endtask

    task automatic test_dwell();
        logic [7:0] vals [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        logic [7:0] exp_q [$];
        logic [7:0] exp_v;
        logic [2:0] ec;
        logic ew;
        do_reset();
        in5 = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        mode5 = 1'b1; en5 = 1'b1;
        for (int e = 0; e < 35; e++) exp_q.push_back(vals[(e / 3) % 5]);
        for (int e = 0; e < 35; e++) begin
            tick();
            exp_v = exp_q.pop_front();
            ec = 3'((e / 3) % 5);
            ew = (e % 15 == 0) && (e > 0);
            n_tests++; if (o5 !== exp_v || v5 !== 1'b1) begin n_fail++; $display("FAIL dwell_out cyc=%0d got out=%0d valid=%0d exp %0d/1", e, o5, v5, exp_v); end
            n_tests++; if (c5 !== ec) begin n_fail++; $display("FAIL dwell_cur cyc=%0d got=%0d exp=%0d", e, c5, ec); end
            n_tests++; if (w5 !== ew) begin n_fail++; $display("FAIL dwell_wrap cyc=%0d got=%0d exp=%0d", e, w5, ew); end
        end
    endtask

    task automatic test_sel_err_switch();
        do_reset();
        in5 = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        mode5 = 1'b0; en5 = 1'b1; sel5 = 3'd6;
        tick();
        n_tests++; if (e5 !== 1'b1 || o5 !== 8'd0 || v5 !== 1'b0 || c5 !== 3'd0)
            begin n_fail++; $display("FAIL sel_err got err=%0d out=%0d valid=%0d cur=%0d exp 1/0/0/0", e5, o5, v5, c5); end
        sel5 = 3'd2;
        tick();
        n_tests++; if (e5 !== 1'b0 || o5 !== 8'd30 || v5 !== 1'b1 || c5 !== 3'd2)
            begin n_fail++; $display("FAIL sel_legal got err=%0d out=%0d valid=%0d cur=%0d exp 0/30/1/2", e5, o5, v5, c5); end
        mode5 = 1'b1; sel5 = 3'd7;
        repeat (10) tick();
        n_tests++; if (c5 !== 3'd3 || o5 !== 8'd40 || e5 !== 1'b0)
            begin n_fail++; $display("FAIL scan_mid got cur=%0d out=%0d err=%0d exp 3/40/0", c5, o5, e5); end
        tick();
        mode5 = 1'b0; sel5 = 3'd1;
        tick();
        n_tests++; if (c5 !== 3'd1 || o5 !== 8'd20 || v5 !== 1'b1 || w5 !== 1'b0)
            begin n_fail++; $display("FAIL switch_direct got cur=%0d out=%0d valid=%0d wrap=%0d exp 1/20/1/0", c5, o5, v5, w5); end
        mode5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (c5 !== 3'd0 || o5 !== 8'd10 || w5 !== 1'b0)
                begin n_fail++; $display("FAIL restart_hold cyc=%0d got cur=%0d out=%0d wrap=%0d exp 0/10/0", i, c5, o5, w5); end
        end
        tick();
        n_tests++; if (c5 !== 3'd1 || o5 !== 8'd20) begin n_fail++; $display("FAIL restart_adv got cur=%0d out=%0d exp 1/20", c5, o5); end
    endtask

    task automatic test_idle();
        do_reset();
        in5 = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        mode5 = 1'b1; en5 = 1'b1;
        repeat (4) tick();
        en5 = 1'b0;
        in5 = '1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (o5 !== 8'd20 || c5 !== 3'd1 || v5 !== 1'b0 || w5 !== 1'b0 || e5 !== 1'b0)
                begin n_fail++; $display("FAIL idle_hold cyc=%0d got out=%0d cur=%0d valid=%0d wrap=%0d err=%0d exp 20/1/0/0/0", i, o5, c5, v5, w5, e5); end
        end
        in5 = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        en5 = 1'b1;
        tick();
        n_tests++; if (o5 !== 8'd10 || c5 !== 3'd0 || v5 !== 1'b1) begin n_fail++; $display("FAIL idle_resume got out=%0d cur=%0d valid=%0d exp 10/0/1", o5, c5, v5); end
    endtask

`ifdef CH_MASK_EN
    task automatic test_mask();
        logic [2:0] seq [6] = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
        logic       wseq [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        in8 = 32'h7654_3210; mask8 = 8'b1001_0010; mode8 = 1'b1; en8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++; if (c8 !== seq[i] || o8 !== 4'(seq[i]) || v8 !== 1'b1)
                begin n_fail++; $display("FAIL mask_seq cyc=%0d got cur=%0d out=%0d valid=%0d exp %0d/%0d/1", i, c8, o8, v8, seq[i], seq[i]); end
            n_tests++; if (w8 !== wseq[i]) begin n_fail++; $display("FAIL mask_wrap cyc=%0d got=%0d exp=%0d", i, w8, wseq[i]); end
        end
        mask8 = 8'h00;
        tick();
        n_tests++; if (v8 !== 1'b0 || o8 !== 4'd7 || c8 !== 3'd7 || w8 !== 1'b0)
            begin n_fail++; $display("FAIL mask_zero got valid=%0d out=%0d cur=%0d wrap=%0d exp 0/7/7/0", v8, o8, c8, w8); end
        mask8 = 8'b0000_0100;
        tick();
        tick();
        n_tests++; if (c8 !== 3'd2 || w8 !== 1'b1) begin n_fail++; $display("FAIL mask_single got cur=%0d wrap=%0d exp 2/1", c8, w8); end
        en8 = 1'b0;
        tick();
        n_tests++; if (v8 !== 1'b0 || o8 !== 4'd2 || c8 !== 3'd2) begin n_fail++; $display("FAIL mask_idle got valid=%0d out=%0d cur=%0d exp 0/2/2", v8, o8, c8); end
        mask8 = 8'b1001_0010; en8 = 1'b1; mode8 = 1'b0; sel8 = 3'd3;
        tick();
        n_tests++; if (o8 !== 4'd0 || v8 !== 1'b0 || e8 !== 1'b0)
            begin n_fail++; $display("FAIL mask_direct got out=%0d valid=%0d err=%0d exp 0/0/0", o8, v8, e8); end
    endtask
`endif

    initial begin
        test_reset();
        test_direct_sweep();
        test_scan_wrap();
        test_dwell();
        test_sel_err_switch();
        test_idle();
`ifdef CH_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
Parametrised, registered N:1 channel multiplexer of WIDTH-bit channels. It is the sequential successor to the fixed 16:1 combinational mux. It runs in one of two modes:
- Direct: the output follows an external select.
- Scan: an internal counter walks all channels in order, holding each for a programmable dwell time.
It is used as a time-division channel sampler feeding serial or monitor logic.

Parameters:
N_CH, 16, number of input channels (>=2; need not be a power of 2)
WIDTH, 1, bits per channel
DWELL, 1, clock cycles spent on each channel in scan mode (>=1)
SEL_W, $clog2(N_CH), select/index width (localparam, derived; not overridable)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
in  input  N_CH*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH]
sel  input  SEL_W  channel select, used in direct mode only
mode  input  1  0 = direct, 1 = scan
en  input  1  block enable
out  output  WIDTH  registered selected channel data
out_valid  output  1  out holds a legal sample taken this cycle
cur_ch  output  SEL_W  index of channel currently presented on out
wrap  output  1  one-cycle pulse when scan wraps from the last channel back to the lowest
sel_err  output  1  registered; high when direct-mode sel >= N_CH

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). All outputs are registered.
- Reset (rst_n=0 at a clk edge): out=0, out_valid=0, cur_ch=0, wrap=0, sel_err=0, dwell counter=0, state=IDLE. Reset mid-scan abandons the scan immediately.
- States: IDLE, DIRECT, SCAN. Evaluated every edge with rst_n=1:
  - en=0 -> IDLE
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
- IDLE: out and cur_ch hold their last values; out_valid=0, wrap=0, sel_err=0.
- DIRECT, latency 1 cycle:
  - Legal sel: out <= channel[sel], cur_ch <= sel, out_valid=1, sel_err=0.
  - sel >= N_CH: out <= 0, cur_ch holds, out_valid=0, sel_err=1.
  - The dwell counter is held at 0.
- SCAN entry: on the first edge in SCAN from any other state, cur_ch <= 0 (or the lowest enabled channel if CH_MASK_EN), dwell <= 0, out <= that channel, out_valid=1, wrap=0.
- SCAN steady state:
  - Each edge: dwell <= dwell+1 and out re-samples the current channel, so out tracks live input during the dwell.
  - When dwell == DWELL-1: advance cur_ch to the next channel, dwell <= 0, and out samples the new channel on that same edge.
  - Advancing from N_CH-1 goes to 0 and asserts wrap for exactly that cycle.
  - With DWELL=1 the block advances every cycle, and wrap asserts once per N_CH cycles.
- Mode switch mid-scan to DIRECT: takes effect next edge. Switching back to SCAN restarts from the entry rule; no resume.
- sel is ignored in SCAN. sel_err is forced 0 outside DIRECT.
- Dwell counter width is $clog2(DWELL+1). There is no arithmetic overflow, because the counter is cleared at DWELL-1.

Optional Feature:
Macro CH_MASK_EN. When defined, an extra input port is present: ch_mask, input, N_CH bits, 1 = channel enabled.
- SCAN: visits only enabled channels, in ascending order with wrap-around. wrap pulses when the next enabled index is <= the current index.
- Single enabled channel: stays on it and pulses wrap every DWELL cycles.
- ch_mask all zero: out holds, cur_ch holds, out_valid=0, wrap=0.
- DIRECT with a masked sel: out <= 0, out_valid=0, sel_err=0.
- Mask changes take effect at the next advance decision.

When CH_MASK_EN is not defined, the port is absent and all channels are enabled.

Test Plan:
1. Reset: drive rst_n=0 for 2 cycles with in=all 1s, mode=1, en=1 -> out=0, out_valid=0, cur_ch=0, wrap=0; the first SCAN sample appears the cycle after rst_n rises.
2. Direct sweep: N_CH=16, WIDTH=1, mode=0, en=1, in=16'h00A5, sel=0..15 each held 1 cycle -> out one cycle later equals bit sel of 16'h00A5 (1,0,1,0,0,1,0,1,0...), out_valid=1, cur_ch=sel.
3. Scan and wrap: N_CH=16, DWELL=1, in=16'h8001, mode=1 -> out pattern 1, then 14 zeros, then 1, repeating; cur_ch 0..15; wrap high only on the cycle cur_ch returns to 0 (period 16).
4. Dwell timing: N_CH=5, WIDTH=8, DWELL=3, channels 10,20,30,40,50 -> each value held 3 cycles; wrap pulses every 15 cycles; wrap is asserted when cur_ch goes from 4 to 0.
5. Illegal select and switching: N_CH=5, mode=0, sel=6 -> sel_err=1, out=0, out_valid=0. Then set mode=1 mid-scan at cur_ch=3, go to mode=0, then back to mode=1 -> scan restarts at cur_ch=0 with dwell=0.
6. Mask (CH_MASK_EN): N_CH=8, ch_mask=8'b1001_0010 -> cur_ch sequence 1,4,7,1,…, with wrap on the 7->1 advance. With ch_mask=0 -> out_valid=0, out holds. With en=0 mid-scan -> IDLE, out holds, out_valid=0.
